adder_ppn_acc: RTL and testbench



---
 rtl/adder_ppn_acc.sv | 181 ++++++++++++++++++
 tb/tb_adder_ppn_acc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_ppn_acc.sv
// Carry-split pipelined two-operand adder with valid/tag pipelining, clock-enable stall,
// signed/unsigned operands and saturating or wrapping output narrowing.
module adder_ppn_acc #(
  parameter int C_IN1    = 12,
  parameter int C_IN2    = 12,
  parameter int C_OUT    = 13,
  parameter int C_PP     = 2,
  parameter int C_SIGNED = 1,
  parameter int C_SAT    = 1,
  parameter int C_USER   = 4
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_ce,
  input  logic              I_vld,
  input  logic [C_IN1-1:0]  I_a,
  input  logic [C_IN2-1:0]  I_b,
  input  logic [C_USER-1:0] I_user,
  output logic              O_vld,
  output logic [C_OUT-1:0]  O_dout,
  output logic              O_ovf,
  output logic [C_USER-1:0] O_user
);

  localparam int WM = (C_IN1 > C_IN2) ? C_IN1 : C_IN2;
  localparam int W  = ((WM + C_PP) / C_PP) * C_PP;
  localparam int S  = W / C_PP;

  logic [W-1:0] a_ext, b_ext;

  if (C_SIGNED != 0) begin : g_sext
    always_comb begin
      a_ext = W'($signed(I_a));
      b_ext = W'($signed(I_b));
    end
  end else begin : g_zext
    always_comb begin
      a_ext = W'(I_a);
      b_ext = W'(I_b);
    end
  end

  // Stage k consumes the low segment of the operand bits still pending and
  // forwards only the untouched upper segments, so each register shrinks/grows
  // to exactly what later stages need.
  for (genvar k = 0; k < C_PP; k++) begin : g_st
    localparam int RW = W - k * S;

    logic [RW-1:0]        a_src, b_src;
    logic                 cin;
    logic [S-1:0]         seg;
    logic [(k+1)*S-1:0]   sum_d, sum_q;
    logic                 vld_d, vld_q;
    logic [C_USER-1:0]    user_d, user_q;

    if (k == 0) begin : g_head
      always_comb begin
        a_src  = a_ext;
        b_src  = b_ext;
        cin    = 1'b0;
        vld_d  = I_vld;
        user_d = I_user;
        sum_d  = seg;
      end
    end else begin : g_body
      always_comb begin
        a_src  = g_st[k-1].g_mid.a_q;
        b_src  = g_st[k-1].g_mid.b_q;
        cin    = g_st[k-1].g_mid.carry_q;
        vld_d  = g_st[k-1].vld_q;
        user_d = g_st[k-1].user_q;
        sum_d  = {seg, g_st[k-1].sum_q};
      end
    end

    if (k < C_PP - 1) begin : g_mid
      logic [RW-S-1:0] a_d, a_q, b_d, b_q;
      logic            carry_d, carry_q;

      always_comb begin
        {carry_d, seg} = {1'b0, a_src[S-1:0]} + {1'b0, b_src[S-1:0]} + (S+1)'(cin);
        a_d = a_src[RW-1:S];
        b_d = b_src[RW-1:S];
      end

      always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
          a_q     <= '0;
          b_q     <= '0;
          carry_q <= 1'b0;
        end else if (I_ce) begin
          a_q     <= a_d;
          b_q     <= b_d;
          carry_q <= carry_d;
        end
      end
    end else begin : g_last
      // W already holds the exact sum, so the top segment's carry-out is dropped.
      always_comb begin
        seg = a_src[S-1:0] + b_src[S-1:0] + S'(cin);
      end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
        sum_q  <= '0;
        vld_q  <= 1'b0;
        user_q <= '0;
      end else if (I_ce) begin
        sum_q  <= sum_d;
        vld_q  <= vld_d;
        user_q <= user_d;
      end
    end
  end

  logic [W-1:0]      fsum;
  logic              res_vld_d, res_vld_q;
  logic [C_OUT-1:0]  res_dout_d, res_dout_q;
  logic              res_ovf_d, res_ovf_q;
  logic [C_USER-1:0] res_user_d, res_user_q;

  always_comb begin
    fsum       = g_st[C_PP-1].sum_q;
    res_vld_d  = g_st[C_PP-1].vld_q;
    res_user_d = g_st[C_PP-1].user_q;
  end

  if (C_OUT >= W) begin : g_widen
    always_comb begin
      res_ovf_d = 1'b0;
      if (C_SIGNED != 0) res_dout_d = C_OUT'($signed(fsum));
      else               res_dout_d = C_OUT'(fsum);
    end
  end else begin : g_narrow
    always_comb begin
      res_ovf_d  = 1'b0;
      res_dout_d = fsum[C_OUT-1:0];
      if (C_SIGNED != 0) begin
        // In range only when every bit above the result sign matches it.
        if (!((&fsum[W-1:C_OUT-1]) || !(|fsum[W-1:C_OUT-1]))) begin
          res_ovf_d = 1'b1;
          if (C_SAT != 0) begin
            if (fsum[W-1]) begin
              res_dout_d          = '0;
              res_dout_d[C_OUT-1] = 1'b1;
            end else begin
              res_dout_d          = '1;
              res_dout_d[C_OUT-1] = 1'b0;
            end
          end
        end
      end else if (|fsum[W-1:C_OUT]) begin
        res_ovf_d = 1'b1;
        if (C_SAT != 0) res_dout_d = '1;
      end
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      res_vld_q  <= 1'b0;
      res_dout_q <= '0;
      res_ovf_q  <= 1'b0;
      res_user_q <= '0;
    end else if (I_ce) begin
      res_vld_q  <= res_vld_d;
      res_dout_q <= res_dout_d;
      res_ovf_q  <= res_ovf_d;
      res_user_q <= res_user_d;
    end
  end

  always_comb begin
    O_vld  = res_vld_q;
    O_dout = res_dout_q;
    O_ovf  = res_ovf_q;
    O_user = res_user_q;
  end

endmodule

// File: tb/tb_adder_ppn_acc.sv
// Scoreboard bench for adder_ppn_acc: six parameterisations share stimulus; a negedge
// monitor pops expected results when each DUT presents an enabled O_vld.
module tb_adder_ppn_acc;

  localparam int ND = 6;
  localparam int COUT [ND] = '{13, 12, 12, 17, 16, 13};
  localparam bit SGN  [ND] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam bit SAT  [ND] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam int LAT  [ND] = '{3, 3, 3, 4, 4, 2};

  typedef struct packed {
    logic [16:0] dout;
    logic        ovf;
    logic [3:0]  user;
    logic [31:0] en;
  } exp_t;

  logic        clk, rst, ce, vld;
  logic [11:0] sa, sb;
  logic [7:0]  ua;
  logic [15:0] ub;
  logic [3:0]  usr;
  logic [3:0]  usr_n;
  logic [31:0] en_cnt;
  logic        ce_edge;

  int checks, passes, fails;
  exp_t q [ND][$];
  exp_t mon_e;
  logic [22:0] prev_o [ND];
  bit have_prev;

  logic        v0, v1, v2, v3, v4, v5;
  logic [12:0] d0, d5;
  logic [11:0] d1, d2;
  logic [16:0] d3;
  logic [15:0] d4;
  logic        f0, f1, f2, f3, f4, f5;
  logic [3:0]  us0, us1, us2, us3, us4, us5;

  logic        o_vld  [ND];
  logic [16:0] o_dout [ND];
  logic        o_ovf  [ND];
  logic [3:0]  o_user [ND];

  adder_ppn_acc #(.C_IN1(12), .C_IN2(12), .C_OUT(13), .C_PP(2), .C_SIGNED(1), .C_SAT(1), .C_USER(4)) u0 (
    .I_clk(clk), .I_rst(rst), .I_ce(ce), .I_vld(vld), .I_a(sa), .I_b(sb), .I_user(usr),
    .O_vld(v0), .O_dout(d0), .O_ovf(f0), .O_user(us0));
  adder_ppn_acc #(.C_IN1(12), .C_IN2(12), .C_OUT(12), .C_PP(2), .C_SIGNED(1), .C_SAT(1), .C_USER(4)) u1 (
    .I_clk(clk), .I_rst(rst), .I_ce(ce), .I_vld(vld), .I_a(sa), .I_b(sb), .I_user(usr),
    .O_vld(v1), .O_dout(d1), .O_ovf(f1), .O_user(us1));
  adder_ppn_acc #(.C_IN1(12), .C_IN2(12), .C_OUT(12), .C_PP(2), .C_SIGNED(1), .C_SAT(0), .C_USER(4)) u2 (
    .I_clk(clk), .I_rst(rst), .I_ce(ce), .I_vld(vld), .I_a(sa), .I_b(sb), .I_user(usr),
    .O_vld(v2), .O_dout(d2), .O_ovf(f2), .O_user(us2));
  adder_ppn_acc #(.C_IN1(8), .C_IN2(16), .C_OUT(17), .C_PP(3), .C_SIGNED(0), .C_SAT(1), .C_USER(4)) u3 (
    .I_clk(clk), .I_rst(rst), .I_ce(ce), .I_vld(vld), .I_a(ua), .I_b(ub), .I_user(usr),
    .O_vld(v3), .O_dout(d3), .O_ovf(f3), .O_user(us3));
  adder_ppn_acc #(.C_IN1(8), .C_IN2(16), .C_OUT(16), .C_PP(3), .C_SIGNED(0), .C_SAT(1), .C_USER(4)) u4 (
    .I_clk(clk), .I_rst(rst), .I_ce(ce), .I_vld(vld), .I_a(ua), .I_b(ub), .I_user(usr),
    .O_vld(v4), .O_dout(d4), .O_ovf(f4), .O_user(us4));
  adder_ppn_acc #(.C_IN1(12), .C_IN2(12), .C_OUT(13), .C_PP(1), .C_SIGNED(1), .C_SAT(1), .C_USER(4)) u5 (
    .I_clk(clk), .I_rst(rst), .I_ce(ce), .I_vld(vld), .I_a(sa), .I_b(sb), .I_user(usr),
    .O_vld(v5), .O_dout(d5), .O_ovf(f5), .O_user(us5));

  always_comb begin
    o_vld[0] = v0; o_dout[0] = 17'(d0); o_ovf[0] = f0; o_user[0] = us0;
    o_vld[1] = v1; o_dout[1] = 17'(d1); o_ovf[1] = f1; o_user[1] = us1;
    o_vld[2] = v2; o_dout[2] = 17'(d2); o_ovf[2] = f2; o_user[2] = us2;
    o_vld[3] = v3; o_dout[3] = d3;      o_ovf[3] = f3; o_user[3] = us3;
    o_vld[4] = v4; o_dout[4] = 17'(d4); o_ovf[4] = f4; o_user[4] = us4;
    o_vld[5] = v5; o_dout[5] = 17'(d5); o_ovf[5] = f5; o_user[5] = us5;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    en_cnt  <= ce ? en_cnt + 32'd1 : en_cnt;
    ce_edge <= ce;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int d, input longint s);
    longint lo, hi, r;
    exp_t e;
    if (SGN[d]) begin
      lo = -(64'sd1 <<< (COUT[d] - 1));
      hi = (64'sd1 <<< (COUT[d] - 1)) - 64'sd1;
    end else begin
      lo = 64'sd0;
      hi = (64'sd1 <<< COUT[d]) - 64'sd1;
    end
    e = '0;
    e.ovf = (s < lo) || (s > hi);
    r = s;
    if (SAT[d] && s > hi) r = hi;
    else if (SAT[d] && s < lo) r = lo;
    e.dout = 17'(r & ((64'sd1 <<< COUT[d]) - 64'sd1));
    return e;
  endfunction

  function automatic int total_q();
    int n;
    n = 0;
    for (int d = 0; d < ND; d++) n += q[d].size();
    return n;
  endfunction

  task automatic step(input logic c, input logic v, input logic [11:0] a, input logic [11:0] b,
                      input logic [7:0] a8, input logic [15:0] b16);
    exp_t e;
    longint s;
    @(posedge clk);
    #1;
    ce = c; vld = v; sa = a; sb = b; ua = a8; ub = b16; usr = usr_n;
    if (c && v) begin
      for (int d = 0; d < ND; d++) begin
        if (SGN[d]) s = longint'($signed(a)) + longint'($signed(b));
        else        s = longint'(a8) + longint'(b16);
        e = model(d, s);
        e.user = usr_n;
        e.en   = en_cnt;
        q[d].push_back(e);
      end
      usr_n++;
    end
  endtask

  task automatic drain();
    int n;
    step(1'b1, 1'b0, 12'd0, 12'd0, 8'd0, 16'd0);
    n = 0;
    while (total_q() > 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_outstanding", 32'(total_q()), 32'd0);
  endtask

  // Consumption point: an O_vld present while I_ce=1 is taken by the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      for (int d = 0; d < ND; d++) begin
        if (have_prev && !ce_edge)
          chk($sformatf("u%0d_stall_hold", d), 32'({o_vld[d], o_dout[d], o_ovf[d], o_user[d]}), 32'(prev_o[d]));
        if (ce && o_vld[d]) begin
          chk($sformatf("u%0d_vld_expected", d), 32'(q[d].size() != 0), 32'd1);
          if (q[d].size() != 0) begin
            mon_e = q[d].pop_front();
            chk($sformatf("u%0d_dout", d), 32'(o_dout[d]), 32'(mon_e.dout));
            chk($sformatf("u%0d_ovf", d), 32'(o_ovf[d]), 32'(mon_e.ovf));
            chk($sformatf("u%0d_user", d), 32'(o_user[d]), 32'(mon_e.user));
            chk($sformatf("u%0d_latency", d), en_cnt - mon_e.en, 32'(LAT[d]));
          end
        end
        prev_o[d] = {o_vld[d], o_dout[d], o_ovf[d], o_user[d]};
      end
      have_prev = 1'b1;
    end
  end

  initial begin
    checks = 0; passes = 0; fails = 0;
    have_prev = 1'b0;
    en_cnt = '0; ce_edge = 1'b1;
    rst = 1'b1; ce = 1'b1; vld = 1'b0;
    sa = '0; sb = '0; ua = '0; ub = '0; usr = '0; usr_n = '0;

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("u%0d_reset_vld", d), 32'(o_vld[d]), 32'd0);
      chk($sformatf("u%0d_reset_dout", d), 32'(o_dout[d]), 32'd0);
      chk($sformatf("u%0d_reset_ovf", d), 32'(o_ovf[d]), 32'd0);
      chk($sformatf("u%0d_reset_user", d), 32'(o_user[d]), 32'd0);
    end
    rst = 1'b0;

    // Directed boundaries: carry into top, most-negative sum, segment-0/1 carry,
    // saturate high, saturate low, mixed-sign in-range, unsigned widen/clamp.
    step(1'b1, 1'b1, 12'd2047, 12'd1,     8'd255, 16'd65535);
    step(1'b1, 1'b1, 12'h800,  12'h800,   8'd0,   16'd0);
    step(1'b1, 1'b1, 12'h07F,  12'h001,   8'd255, 16'd0);
    step(1'b1, 1'b0, 12'h123,  12'h456,   8'd9,   16'd9);
    step(1'b1, 1'b1, 12'd2047, 12'd2047,  8'd1,   16'hFFFF);
    step(1'b1, 1'b1, 12'h800,  12'hFFF,   8'd128, 16'h8000);
    step(1'b1, 1'b1, 12'd100,  12'hFCE,   8'd17,  16'd1000);
    drain();

    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b1, 12'($urandom), 12'($urandom), 8'($urandom), 16'($urandom));
    drain();

    // Stalls of 3 cycles and 1 cycle inside an 8-result stream; stalled cycles
    // drive junk with I_vld=1, which must be ignored.
    begin
      int sent;
      logic cc;
      sent = 0;
      for (int c = 0; c < 12; c++) begin
        cc = !((c >= 2 && c <= 4) || c == 6);
        if (cc && sent < 8) begin
          step(1'b1, 1'b1, 12'($urandom), 12'($urandom), 8'($urandom), 16'($urandom));
          sent++;
        end else begin
          step(cc, !cc, 12'($urandom), 12'($urandom), 8'($urandom), 16'($urandom));
        end
      end
      chk("stall_inputs_sent", 32'(sent), 32'd8);
    end
    drain();

    // Reset with results in flight.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 12'($urandom), 12'($urandom), 8'($urandom), 16'($urandom));
    step(1'b1, 1'b0, 12'd0, 12'd0, 8'd0, 16'd0);
    chk("u0_pre_reset_vld", 32'(o_vld[0]), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("u%0d_async_rst_vld", d), 32'(o_vld[d]), 32'd0);
      chk($sformatf("u%0d_async_rst_dout", d), 32'(o_dout[d]), 32'd0);
      chk($sformatf("u%0d_async_rst_ovf", d), 32'(o_ovf[d]), 32'd0);
      chk($sformatf("u%0d_async_rst_user", d), 32'(o_user[d]), 32'd0);
      q[d].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++)
        chk($sformatf("u%0d_post_rst_vld", d), 32'(o_vld[d]), 32'd0);
    end

    // Fresh traffic after reset still flows.
    step(1'b1, 1'b1, 12'd2047, 12'd1, 8'd255, 16'd65535);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
